settings_menu_ctrl: RTL
=======================

# settings_menu_ctrl

Parametrised settings controller for the pre-game menu: holds NUM_ITEMS bounded settings, moves a cursor between them, and steps the selected value from the player's direction keys with hold-to-repeat. While `game_started` is high, a committed snapshot of all values is frozen and fed to the game logic (sound, theme, starting hearts, and later additions). It sits between the keypad debouncers and the menu renderer / game core.

## Interface
Parameters:
- NUM_ITEMS, 3, number of settings (≥1)
- VAL_W, 3, width of every setting value
- ITEM_MIN, {3'd1,1'd0,1'd0}-style packed [NUM_ITEMS-1:0][VAL_W-1:0], per-item inclusive minimum (default all 0 except item 2 = 1)
- ITEM_MAX, packed as above, per-item inclusive maximum (default item0 = 1, item1 = 1, item2 = 6)
- ITEM_DEFAULT, packed as above, reset value (default item0 = 0, item1 = 0, item2 = 3)
- ITEM_WRAP, NUM_ITEMS-bit mask, 1 = value wraps max↔min, 0 = saturates (default 3'b011)
- REPEAT_DELAY, 16, cycles a left/right key is held before auto-repeat starts
- REPEAT_RATE, 4, cycles between auto-repeat steps (≥1)

Ports (reset resetN, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- game_started  in  1  level; high = settings locked
- key_up  in  1  debounced level, cursor to previous item
- key_down  in  1  debounced level, cursor to next item
- key_left  in  1  debounced level, decrement selected value
- key_right  in  1  debounced level, increment selected value
- cursor  out  CUR_W  selected item index, CUR_W = max(1,$clog2(NUM_ITEMS))
- work_values  out  NUM_ITEMS*VAL_W  live menu values (renderer)
- cfg_values  out  NUM_ITEMS*VAL_W  committed values (game core)
- locked  out  1  high in LOCKED state
- value_changed  out  1  one-cycle pulse when any work value changes

## Operation
- Reset: cursor=0, work_values=cfg_values=ITEM_DEFAULT, locked=0, value_changed=0, state BROWSE, repeat counters cleared.
- States: BROWSE, LOCKED.
- BROWSE→LOCKED on game_started=1: cfg_values←work_values (values before any same-cycle key action); key actions that cycle are discarded.
- LOCKED→BROWSE on game_started=0; work_values retained, cfg_values held until next lock. In LOCKED all keys ignored, repeat counters held at 0.
- Up/down: rising edge only, no repeat. Cursor wraps (0 -up→ NUM_ITEMS-1, NUM_ITEMS-1 -down→ 0). Both edges same cycle → no move.
- Left/right: step on rising edge, then if still held, one step after REPEAT_DELAY cycles, then every REPEAT_RATE cycles. Both held → no step, counters reset; release of one restarts the other's delay.
- Step rules for selected item i: increment at ITEM_MAX[i] → ITEM_MIN[i] if ITEM_WRAP[i], else unchanged; decrement at ITEM_MIN[i] symmetric. Value outside [min,max] (never expected) is clamped to nearest bound on next step.
- Cursor move and value step in same cycle: step applies to the item selected before the move.
- value_changed pulses only if the stored value actually differs (saturated steps produce no pulse).

## Timing
- Key edge at cycle n (level sampled high, previous low) → cursor/work_values updated at edge n+1, value_changed high during cycle n+1.
- Auto-repeat: with key high from sample n, steps at n+1, n+1+REPEAT_DELAY, then every REPEAT_RATE.
- Lock snapshot visible on cfg_values and locked one cycle after game_started first samples high.
- Reset mid-hold: all state to reset values immediately; a key still held after reset release needs a fresh rising edge (edge registers reset to 1 = "already pressed" to suppress it).

## Structure
- Package settings_pkg: item index constants (SET_SOUND=0, SET_THEME=1, SET_HEARTS=2), default MIN/MAX/DEFAULT/WRAP constant vectors, state enum typedef, cur_w() function.
- Sub-module key_repeater (edge detect + delay/rate counter, params REPEAT_DELAY, REPEAT_RATE, EN_REPEAT), instantiated four times (repeat disabled for up/down); emits one-cycle step pulse; input `hold_off` forces idle.

## Test plan
- Reset with defaults → work=cfg={0,0,3}, cursor=0, locked=0; no value_changed.
- cursor→2, right ×3 edges → hearts 4,5,6; fourth right → stays 6 (saturate), no value_changed pulse.
- cursor 0 (sound, wrap), right twice → 1 then 0; up at cursor 0 → cursor 2.
- cursor 2, hold left 60 cycles (delay 16, rate 4) → steps at cycles 1,17,21… value reaches 1 and saturates; exact step count matches formula.
- Right edge same cycle game_started rises with hearts=3 → cfg hearts=3, work hearts=3, locked=1; keys in LOCKED ignored; game_started falls → BROWSE, cfg unchanged.
- Assert resetN mid auto-repeat with key held → defaults restored; no step after reset release until key released and pressed again.

Source files
------------

// File: rtl/settings_menu_ctrl_pkg.sv
// Shared constants for the pre-game settings menu: item indices, default bounds, FSM states.
// Pure declarations, no logic and no timing.
package settings_pkg;

    localparam int SET_SOUND  = 0;
    localparam int SET_THEME  = 1;
    localparam int SET_HEARTS = 2;

    localparam int DEF_NUM_ITEMS = 3;
    localparam int DEF_VAL_W     = 3;

    localparam logic [DEF_NUM_ITEMS-1:0][DEF_VAL_W-1:0] DEF_ITEM_MIN     = {3'd1, 3'd0, 3'd0};
    localparam logic [DEF_NUM_ITEMS-1:0][DEF_VAL_W-1:0] DEF_ITEM_MAX     = {3'd6, 3'd1, 3'd1};
    localparam logic [DEF_NUM_ITEMS-1:0][DEF_VAL_W-1:0] DEF_ITEM_DEFAULT = {3'd3, 3'd0, 3'd0};
    localparam logic [DEF_NUM_ITEMS-1:0]                DEF_ITEM_WRAP    = 3'b011;

    typedef enum logic {
        ST_BROWSE = 1'b0,
        ST_LOCKED = 1'b1
    } menu_state_t;

    function automatic int cur_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/settings_menu_ctrl_if.sv
// Menu bus: debounced keypad levels and lock request in, cursor/values/status out.
// Wires only; the master drives keys, the slave (controller) drives menu state.
interface settings_menu_ctrl_if #(
    parameter int NUM_ITEMS = 3,
    parameter int VAL_W     = 3
);
    import settings_pkg::*;

    localparam int CUR_W = cur_w(NUM_ITEMS);

    logic                       game_started;
    logic                       key_up;
    logic                       key_down;
    logic                       key_left;
    logic                       key_right;
    logic [CUR_W-1:0]           cursor;
    logic [NUM_ITEMS*VAL_W-1:0] work_values;
    logic [NUM_ITEMS*VAL_W-1:0] cfg_values;
    logic                       locked;
    logic                       value_changed;

    modport master (
        output game_started, key_up, key_down, key_left, key_right,
        input  cursor, work_values, cfg_values, locked, value_changed
    );

    modport slave (
        input  game_started, key_up, key_down, key_left, key_right,
        output cursor, work_values, cfg_values, locked, value_changed
    );

endinterface

// File: rtl/settings_menu_ctrl_key_repeater.sv
// Turns a key level into step pulses: one on the press edge, then after REPEAT_DELAY, then every REPEAT_RATE.
// step is combinational in the cycle it applies; hold_off suppresses steps and idles the counter.
module key_repeater #(
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    parameter bit EN_REPEAT    = 1'b1
) (
    input  logic clk,
    input  logic resetN,
    input  logic key,
    input  logic hold_off,
    output logic step
);
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             key_q;
    logic             armed;
    logic             active;
    logic             rep_phase;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             fire;

    assign rise = key & ~key_q;

    always_comb begin
        fire = 1'b0;
        if (EN_REPEAT && active && key && !hold_off)
            fire = rep_phase ? (cnt == CNT_W'(REPEAT_RATE)) : (cnt == CNT_W'(REPEAT_DELAY));
    end

    assign step = (rise & ~hold_off) | fire;

    // key_q resets high so a key held through reset is not mistaken for a new press;
    // armed marks a press that was accepted, letting its delay restart after an inhibit clears.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_q     <= 1'b1;
            armed     <= 1'b0;
            active    <= 1'b0;
            rep_phase <= 1'b0;
            cnt       <= '0;
        end else begin
            key_q <= key;
            if (!key) begin
                armed     <= 1'b0;
                active    <= 1'b0;
                rep_phase <= 1'b0;
                cnt       <= '0;
            end else if (hold_off) begin
                active    <= 1'b0;
                rep_phase <= 1'b0;
                cnt       <= '0;
            end else if (rise) begin
                armed     <= 1'b1;
                active    <= 1'b1;
                rep_phase <= 1'b0;
                cnt       <= CNT_W'(1);
            end else if (!active) begin
                if (armed) begin
                    active    <= 1'b1;
                    rep_phase <= 1'b0;
                    cnt       <= CNT_W'(1);
                end
            end else if (fire) begin
                rep_phase <= 1'b1;
                cnt       <= CNT_W'(1);
            end else if (cnt != CNT_W'(CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/settings_menu_ctrl.sv
// Pre-game settings menu: cursor, bounded per-item values with hold-to-repeat, and a snapshot frozen while the game runs.
// Key or lock effects are registered one cycle after the input is sampled.
module settings_menu_ctrl
    import settings_pkg::*;
#(
    parameter int                                NUM_ITEMS    = DEF_NUM_ITEMS,
    parameter int                                VAL_W        = DEF_VAL_W,
    parameter logic [NUM_ITEMS-1:0][VAL_W-1:0]   ITEM_MIN     = DEF_ITEM_MIN,
    parameter logic [NUM_ITEMS-1:0][VAL_W-1:0]   ITEM_MAX     = DEF_ITEM_MAX,
    parameter logic [NUM_ITEMS-1:0][VAL_W-1:0]   ITEM_DEFAULT = DEF_ITEM_DEFAULT,
    parameter logic [NUM_ITEMS-1:0]              ITEM_WRAP    = DEF_ITEM_WRAP,
    parameter int                                REPEAT_DELAY = 16,
    parameter int                                REPEAT_RATE  = 4
) (
    input  logic                 clk,
    input  logic                 resetN,
    settings_menu_ctrl_if.slave  bus
);
    localparam int CUR_W = cur_w(NUM_ITEMS);

    menu_state_t                     state_q, state_d;
    logic [CUR_W-1:0]                cur_q, cur_d;
    logic [NUM_ITEMS-1:0][VAL_W-1:0] work_q, work_d;
    logic [NUM_ITEMS-1:0][VAL_W-1:0] cfg_q, cfg_d;
    logic                            vc_q, vc_d;
    logic                            hold_all;
    logic                            step_up, step_down, step_left, step_right;

    // The lock request itself also inhibits keys, so actions in the locking cycle are dropped.
    assign hold_all = bus.game_started | (state_q == ST_LOCKED);

    key_repeater #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .EN_REPEAT(1'b0)) u_rep_up (
        .clk(clk), .resetN(resetN), .key(bus.key_up), .hold_off(hold_all), .step(step_up));
    key_repeater #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .EN_REPEAT(1'b0)) u_rep_down (
        .clk(clk), .resetN(resetN), .key(bus.key_down), .hold_off(hold_all), .step(step_down));
    key_repeater #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .EN_REPEAT(1'b1)) u_rep_left (
        .clk(clk), .resetN(resetN), .key(bus.key_left), .hold_off(hold_all | bus.key_right), .step(step_left));
    key_repeater #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .EN_REPEAT(1'b1)) u_rep_right (
        .clk(clk), .resetN(resetN), .key(bus.key_right), .hold_off(hold_all | bus.key_left), .step(step_right));

    // Out-of-range values snap to the nearest bound instead of stepping.
    function automatic logic [VAL_W-1:0] next_val(
        input logic [VAL_W-1:0] v,
        input logic [VAL_W-1:0] lo,
        input logic [VAL_W-1:0] hi,
        input logic             wrap,
        input logic             inc
    );
        if (inc) begin
            if (v < lo)  return lo;
            if (v >= hi) return (wrap && (v == hi)) ? lo : hi;
            return v + VAL_W'(1);
        end else begin
            if (v > hi)  return hi;
            if (v <= lo) return (wrap && (v == lo)) ? hi : lo;
            return v - VAL_W'(1);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        work_d  = work_q;
        cfg_d   = cfg_q;
        vc_d    = 1'b0;
        if (state_q == ST_BROWSE) begin
            if (bus.game_started) begin
                cfg_d   = work_q;
                state_d = ST_LOCKED;
            end else begin
                if (step_up && !step_down)
                    cur_d = (cur_q == '0) ? CUR_W'(NUM_ITEMS - 1) : cur_q - CUR_W'(1);
                else if (step_down && !step_up)
                    cur_d = (cur_q == CUR_W'(NUM_ITEMS - 1)) ? '0 : cur_q + CUR_W'(1);
                if (step_left ^ step_right) begin
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (cur_q == CUR_W'(i))
                            work_d[i] = next_val(work_q[i], ITEM_MIN[i], ITEM_MAX[i], ITEM_WRAP[i], step_right);
                    end
                end
            end
        end else begin
            if (!bus.game_started)
                state_d = ST_BROWSE;
        end
        vc_d = (work_d != work_q);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_BROWSE;
            cur_q   <= '0;
            work_q  <= ITEM_DEFAULT;
            cfg_q   <= ITEM_DEFAULT;
            vc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            work_q  <= work_d;
            cfg_q   <= cfg_d;
            vc_q    <= vc_d;
        end
    end

    assign bus.cursor        = cur_q;
    assign bus.work_values   = work_q;
    assign bus.cfg_values    = cfg_q;
    assign bus.locked        = (state_q == ST_LOCKED);
    assign bus.value_changed = vc_q;

endmodule
